alu_serial_ctrl: RTL and testbench

Sequencer that runs a full-width ALU operation through the codebase's single-bit ALU slice, one bit per clock, LSB first. It latches the operands and the 4-bit ALU control code, drives the slice every cycle, routes its carry back into the next bit, and assembles the serial results into a WIDTH-bit result. For set-less-than it runs two passes: a subtract pass to find the sign, then an SLT pass. It serves as the area-minimal execute path and as a test harness for the slice. Start/busy/done handshake toward the requester.

---
 rtl/alu_serial_ctrl.sv | 151 +++++++++++++++
 tb/tb_alu_serial_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: drives a 1-bit ALU slice LSB first and assembles a WIDTH-bit result.
// Latency: WIDTH+1 cycles from accepted start to done (2*WIDTH+1 for SLT).
// Backpressure: none; start is only accepted while busy=0 and is ignored otherwise.
module alu_serial_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [3:0]       alu_ctl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic             slice_slt,
    output logic [3:0]       slice_ctl,
    input  logic             slice_out,
    input  logic             slice_cout
);

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [3:0]    CTL_IDLE = 4'b0000;
    localparam logic [3:0]    CTL_ADD  = 4'b0010;
    localparam logic [3:0]    CTL_SUB  = 4'b0110;
    localparam logic [3:0]    CTL_SLT  = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SLT2 = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       ctl_q;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             less_q;
    logic             accept;
    logic             last_bit;
    logic             ovf_raw;
    logic             less_raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        slice_a   = 1'b0;
        slice_b   = 1'b0;
        slice_cin = 1'b0;
        slice_slt = 1'b0;
        slice_ctl = CTL_IDLE;
        last_bit  = (cnt == CNT_LAST);
        // Signed overflow uses the carry into the MSB versus the carry out of it.
        ovf_raw   = carry ^ slice_cout;
        less_raw  = slice_out ^ ovf_raw;

        case (state)
            IDLE: begin
                accept = start;
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy      = 1'b1;
                slice_a   = a_q[cnt];
                slice_b   = b_q[cnt];
                slice_cin = carry;
                slice_ctl = (ctl_q == CTL_SLT) ? CTL_SUB : ctl_q;
                if (last_bit) begin
                    state_nxt = (ctl_q == CTL_SLT) ? SLT2 : FIN;
                end
            end
            SLT2: begin
                busy      = 1'b1;
                slice_a   = a_q[cnt];
                slice_b   = b_q[cnt];
                slice_cin = carry;
                slice_ctl = CTL_SLT;
                slice_slt = (cnt == '0) ? less_q : 1'b0;
                if (last_bit) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                done      = 1'b1;
                accept    = start;
                state_nxt = start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            ctl_q  <= CTL_IDLE;
            cnt    <= '0;
            carry  <= 1'b0;
            less_q <= 1'b0;
            result <= '0;
            ovf    <= 1'b0;
        end else if (accept) begin
            a_q   <= op_a;
            b_q   <= op_b;
            ctl_q <= alu_ctl;
            cnt   <= '0;
            carry <= alu_ctl[2];
        end else if ((state == RUN) || (state == SLT2)) begin
            result[cnt] <= slice_out;
            carry       <= slice_cout;
            cnt         <= cnt + CW'(1);
            if (last_bit) begin
                cnt <= '0;
                if (state == RUN) begin
                    if (ctl_q == CTL_SLT) begin
                        less_q <= less_raw;
                        carry  <= 1'b1;
                        ovf    <= 1'b0;
                    end else begin
                        ovf <= ((ctl_q == CTL_ADD) || (ctl_q == CTL_SUB)) ? ovf_raw : 1'b0;
                    end
                end
            end
        end
    end

    assign zero = (result == '0);

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Bench for alu_serial_ctrl at WIDTH=8 with a behavioural 1-bit ALU slice.
module tb_alu_serial_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [3:0]   alu_ctl;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         zero;
    logic         ovf;
    logic         slice_a;
    logic         slice_b;
    logic         slice_cin;
    logic         slice_slt;
    logic [3:0]   slice_ctl;
    logic         slice_out;
    logic         slice_cout;

    int total = 0;
    int fails = 0;
    int lat;

    always #5 clk = ~clk;

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op_a      (op_a),
        .op_b      (op_b),
        .alu_ctl   (alu_ctl),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .zero      (zero),
        .ovf       (ovf),
        .slice_a   (slice_a),
        .slice_b   (slice_b),
        .slice_cin (slice_cin),
        .slice_slt (slice_slt),
        .slice_ctl (slice_ctl),
        .slice_out (slice_out),
        .slice_cout(slice_cout)
    );

    // Standard slice: B inverted for SUB/SLT, SLT forwards the less input.
    logic b_eff;
    logic s_sum;
    logic s_cy;
    always_comb begin
        b_eff      = slice_ctl[2] ? ~slice_b : slice_b;
        s_sum      = slice_a ^ b_eff ^ slice_cin;
        s_cy       = (slice_a & b_eff) | (slice_a & slice_cin) | (b_eff & slice_cin);
        slice_out  = 1'b0;
        slice_cout = 1'b0;
        case (slice_ctl)
            4'b0000: slice_out = slice_a & slice_b;
            4'b0001: slice_out = slice_a | slice_b;
            4'b0010, 4'b0110: begin
                slice_out  = s_sum;
                slice_cout = s_cy;
            end
            4'b0111: begin
                slice_out  = slice_slt;
                slice_cout = s_cy;
            end
            4'b1100: slice_out = slice_a ^ slice_b;
            default: ;
        endcase
    end

    typedef struct {
        logic [3:0]   ctl;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         ovf;
        int           lat;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        start   = 1'b1;
        alu_ctl = c;
        op_a    = a;
        op_b    = b;
        tick();
        start = 1'b0;
        lat   = 1;
    endtask

    task automatic wait_done();
        while (!done && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        vecs[0]  = '{4'b0010, 8'h7F, 8'h01, 8'h80, 1'b1, 9};
        vecs[1]  = '{4'b0010, 8'hFF, 8'h01, 8'h00, 1'b0, 9};
        vecs[2]  = '{4'b0110, 8'h05, 8'h07, 8'hFE, 1'b0, 9};
        vecs[3]  = '{4'b0110, 8'h33, 8'h33, 8'h00, 1'b0, 9};
        vecs[4]  = '{4'b0110, 8'h80, 8'h01, 8'h7F, 1'b1, 9};
        vecs[5]  = '{4'b0111, 8'h80, 8'h01, 8'h01, 1'b0, 17};
        vecs[6]  = '{4'b0111, 8'h01, 8'h80, 8'h00, 1'b0, 17};
        vecs[7]  = '{4'b0111, 8'hFF, 8'h00, 8'h01, 1'b0, 17};
        vecs[8]  = '{4'b0000, 8'hF0, 8'h3C, 8'h30, 1'b0, 9};
        vecs[9]  = '{4'b0001, 8'hF0, 8'h3C, 8'hFC, 1'b0, 9};
        vecs[10] = '{4'b1100, 8'hF0, 8'h3C, 8'hCC, 1'b0, 9};
        vecs[11] = '{4'b1111, 8'hF0, 8'h3C, 8'h00, 1'b0, 9};

        // Reset with start held high: reset must win.
        rst     = 1'b1;
        start   = 1'b1;
        op_a    = 8'hAA;
        op_b    = 8'h55;
        alu_ctl = 4'b0010;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_zero", zero, 1);
        chk("rst_slice_ctl", slice_ctl, 0);
        chk("rst_slice_bits", {slice_a, slice_b, slice_cin, slice_slt}, 0);
        start = 1'b0;
        rst   = 1'b0;
        tick();

        for (int i = 0; i < 12; i++) begin
            start_op(vecs[i].ctl, vecs[i].a, vecs[i].b);
            wait_done();
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_result", i), result, vecs[i].res);
            chk($sformatf("v%0d_ovf", i), ovf, vecs[i].ovf);
            chk($sformatf("v%0d_zero", i), zero, (vecs[i].res == 0));
            chk($sformatf("v%0d_busy_in_done", i), busy, 0);
            tick();
            chk($sformatf("v%0d_done_pulse", i), done, 0);
        end

        // Start pulsed at cycle 3 of a busy ADD is ignored.
        start_op(4'b0010, 8'h7F, 8'h01);
        tick();
        tick();
        lat = 3;
        start   = 1'b1;
        alu_ctl = 4'b0000;
        op_a    = 8'h00;
        op_b    = 8'h00;
        tick();
        lat++;
        start = 1'b0;
        chk("ign_busy", busy, 1);
        wait_done();
        chk("ign_latency", lat, 9);
        chk("ign_result", result, 8'h80);
        chk("ign_ovf", ovf, 1);

        // Back-to-back: start driven in the done cycle.
        start_op(4'b0110, 8'h05, 8'h07);
        chk("b2b_busy", busy, 1);
        wait_done();
        chk("b2b_latency", lat, 9);
        chk("b2b_result", result, 8'hFE);

        // SLT second pass drives the less bit only on bit 0.
        tick();
        start_op(4'b0111, 8'h80, 8'h01);
        chk("slt_run_ctl", slice_ctl, 4'b0110);
        chk("slt_run_cin", slice_cin, 1);
        while (lat < 9) begin
            tick();
            lat++;
        end
        chk("slt2_ctl", slice_ctl, 4'b0111);
        chk("slt2_less_bit0", slice_slt, 1);
        chk("slt2_cin", slice_cin, 1);
        tick();
        lat++;
        chk("slt2_less_bit1", slice_slt, 0);
        wait_done();
        chk("slt2_latency", lat, 17);
        chk("slt2_result", result, 8'h01);

        // Reset at cycle 4 of an SLT aborts without a done pulse.
        tick();
        start_op(4'b0111, 8'h80, 8'h01);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_result", result, 0);
        chk("abort_done", done, 0);
        chk("abort_slice_ctl", slice_ctl, 0);
        begin
            int pulses;
            pulses = 0;
            for (int k = 0; k < 25; k++) begin
                if (done) pulses++;
                tick();
            end
            chk("abort_no_done", pulses, 0);
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
